// File: rtl/mult_mac_seq_if.sv
// mult_mac_seq_if -- Wishbone slave bus bundle for mult_mac_seq.
//   master : drives ADR/CYC/BYTE_STB/WE/STB/DAT_i, receives DAT_o/ACK_o
//   slave  : receives the request, returns DAT_o (read data) and ACK_o
interface mult_mac_seq_if #(
    parameter int ADDRWIDTH = 7
);
    logic [ADDRWIDTH-1:0] WBs_ADR_i;
    logic                 WBs_CYC_i;
    logic [3:0]           WBs_BYTE_STB_i;
    logic                 WBs_WE_i;
    logic                 WBs_STB_i;
    logic [31:0]          WBs_DAT_i;
    logic [31:0]          WBs_DAT_o;
    logic                 WBs_ACK_o;

    modport master (
        output WBs_ADR_i, WBs_CYC_i, WBs_BYTE_STB_i, WBs_WE_i, WBs_STB_i, WBs_DAT_i,
        input  WBs_DAT_o, WBs_ACK_o
    );

    modport slave (
        input  WBs_ADR_i, WBs_CYC_i, WBs_BYTE_STB_i, WBs_WE_i, WBs_STB_i, WBs_DAT_i,
        output WBs_DAT_o, WBs_ACK_o
    );
endinterface

// File: rtl/mult_mac_seq.sv
// mult_mac_seq -- Wishbone-controlled sequential multiply-accumulate engine.
// Operand pairs are queued in a FIFO, fed one at a time to an external 16x16
// multiplier and the products summed into a 40-bit accumulator.
//   WBs_CLK_i / WBs_RST_i : clock, asynchronous active-high reset
//   wb                    : Wishbone slave (register map CTRL/STATUS/OPERAND/ACC)
//   Amult_o / Bmult_o     : registered operands to the multiplier cell
//   Valid_mult_o          : operands valid while a run is in progress
//   Cmult_i               : product returned by the multiplier cell
//   Irq_o                 : done & IRQ_EN
module mult_mac_seq #(
    parameter int ADDRWIDTH  = 7,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 WBs_CLK_i,
    input  logic                 WBs_RST_i,
    mult_mac_seq_if.slave        wb,
    output logic [15:0]          Amult_o,
    output logic [15:0]          Bmult_o,
    output logic                 Valid_mult_o,
    input  logic [31:0]          Cmult_i,
    output logic                 Irq_o
);
    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_POP   = 3'd1;
    localparam logic [2:0] S_MULT  = 3'd2;
    localparam logic [2:0] S_ACCUM = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0] count_q, count_d;
    logic [39:0] acc_q, acc_d;
    logic [15:0] pair_cnt_q, pair_cnt_d;
    logic [31:0] prod_q, prod_d;
    logic        done_q, done_d;
    logic        acc_ovf_q, acc_ovf_d;
    logic        push_err_q, push_err_d;
    logic        irq_en_q, irq_en_d;
    logic [15:0] amult_q, amult_d, bmult_q, bmult_d;
    logic        valid_q, valid_d;
    logic        ack_q, ack_d;
    logic [31:0] mem_q [FIFO_DEPTH];

    logic        wr, wr_ctrl, wr_stat, wr_op, start, clr, busy;
    logic        fifo_full, fifo_empty, push, pop;
    logic [40:0] acc_sum;
    logic [31:0] fifo_head, rdata;
    logic [3:0]  count4;
    logic        unused_bits;

    assign unused_bits = ^wb.WBs_BYTE_STB_i[3:1];

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        acc_d      = acc_q;
        pair_cnt_d = pair_cnt_q;
        prod_d     = prod_q;
        done_d     = done_q;
        acc_ovf_d  = acc_ovf_q;
        push_err_d = push_err_q;
        irq_en_d   = irq_en_q;
        amult_d    = amult_q;
        bmult_d    = bmult_q;
        valid_d    = valid_q;
        pop        = 1'b0;

        ack_d   = wb.WBs_CYC_i & wb.WBs_STB_i & ~ack_q;
        wr      = ack_d & wb.WBs_WE_i;
        wr_ctrl = wr & (wb.WBs_ADR_i == ADDRWIDTH'(0)) & wb.WBs_BYTE_STB_i[0];
        wr_stat = wr & (wb.WBs_ADR_i == ADDRWIDTH'(1));
        wr_op   = wr & (wb.WBs_ADR_i == ADDRWIDTH'(2)) & wb.WBs_BYTE_STB_i[0];
        start   = wr_ctrl & wb.WBs_DAT_i[0];
        clr     = wr_ctrl & wb.WBs_DAT_i[1];
        busy    = (state_q == S_POP) || (state_q == S_MULT) || (state_q == S_ACCUM);

        fifo_full  = (count_q == (PW+1)'(FIFO_DEPTH));
        fifo_empty = (count_q == '0);
        push       = wr_op & ~fifo_full;
        fifo_head  = mem_q[rd_ptr_q];
        acc_sum    = {1'b0, acc_q} + {9'b0, prod_q};

        if (wr_op && fifo_full) push_err_d = 1'b1;
        if (wr_ctrl)            irq_en_d   = wb.WBs_DAT_i[2];
        if (wr_stat) begin
            if (wb.WBs_DAT_i[4]) acc_ovf_d  = 1'b0;
            if (wb.WBs_DAT_i[5]) push_err_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    done_d  = 1'b0;
                    state_d = fifo_empty ? S_DONE : S_POP;
                end
            end
            S_POP: begin
                pop     = 1'b1;
                amult_d = fifo_head[15:0];
                bmult_d = fifo_head[31:16];
                valid_d = 1'b1;
                state_d = S_MULT;
            end
            S_MULT: begin
                prod_d  = Cmult_i;
                state_d = S_ACCUM;
            end
            S_ACCUM: begin
                acc_d      = acc_sum[39:0];
                pair_cnt_d = pair_cnt_q + 16'd1;
                if (acc_sum[40]) acc_ovf_d = 1'b1;
                // Empty check sees pushes that completed before this cycle.
                state_d = fifo_empty ? S_DONE : S_POP;
            end
            S_DONE: begin
                done_d  = 1'b1;
                valid_d = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Evaluated after the FSM so a clear issued in DONE also drops done;
        // a combined START+CLR in IDLE therefore runs on a cleared accumulator.
        if (clr && !busy) begin
            acc_d      = '0;
            pair_cnt_d = '0;
            done_d     = 1'b0;
        end

        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (push && !pop)      count_d = count_q + (PW+1)'(1);
        else if (pop && !push) count_d = count_q - (PW+1)'(1);
    end

    assign count4 = 4'(count_q);

    always_comb begin
        rdata = 32'hFABDEFAC;
        case (wb.WBs_ADR_i)
            ADDRWIDTH'(0): rdata = {29'b0, irq_en_q, 2'b0};
            ADDRWIDTH'(1): rdata = {20'b0, count4, 2'b0, push_err_q, acc_ovf_q,
                                    fifo_empty, fifo_full, done_q, busy};
            ADDRWIDTH'(3): rdata = acc_q[31:0];
            ADDRWIDTH'(4): rdata = {24'b0, acc_q[39:32]};
            ADDRWIDTH'(5): rdata = {16'b0, pair_cnt_q};
            default:       rdata = 32'hFABDEFAC;
        endcase
    end

    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            acc_q      <= '0;
            pair_cnt_q <= '0;
            prod_q     <= '0;
            done_q     <= 1'b0;
            acc_ovf_q  <= 1'b0;
            push_err_q <= 1'b0;
            irq_en_q   <= 1'b0;
            amult_q    <= '0;
            bmult_q    <= '0;
            valid_q    <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            acc_q      <= acc_d;
            pair_cnt_q <= pair_cnt_d;
            prod_q     <= prod_d;
            done_q     <= done_d;
            acc_ovf_q  <= acc_ovf_d;
            push_err_q <= push_err_d;
            irq_en_q   <= irq_en_d;
            amult_q    <= amult_d;
            bmult_q    <= bmult_d;
            valid_q    <= valid_d;
            ack_q      <= ack_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge WBs_CLK_i) begin
        if (push) mem_q[wr_ptr_q] <= wb.WBs_DAT_i;
    end

    assign wb.WBs_DAT_o = rdata;
    assign wb.WBs_ACK_o = ack_q;
    assign Amult_o      = amult_q;
    assign Bmult_o      = bmult_q;
    assign Valid_mult_o = valid_q;
    assign Irq_o        = done_q & irq_en_q;
endmodule

// File: doc/mult_mac_seq.md
MULT_MAC_SEQ -- requirements
Module: mult_mac_seq

Interface
REQ-001 SHALL have parameter ADDRWIDTH, default 7, the Wishbone word-address width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, the operand FIFO depth in entries (power of 2).
REQ-003 SHALL have port WBs_CLK_i, input, 1, clock.
REQ-004 SHALL have port WBs_RST_i, input, 1, reset: asynchronous, active-high.
REQ-005 SHALL have ports WBs_ADR_i (input, ADDRWIDTH), WBs_CYC_i (input, 1), WBs_BYTE_STB_i (input, 4), WBs_WE_i (input, 1), WBs_STB_i (input, 1) and WBs_DAT_i (input, 32), forming the Wishbone slave request.
REQ-006 SHALL have port WBs_DAT_o, output, 32, read data.
REQ-007 SHALL have port WBs_ACK_o, output, 1, transfer acknowledge.
REQ-008 SHALL have ports Amult_o (output, 16), Bmult_o (output, 16) and Valid_mult_o (output, 1), the operands driven to the external 16x16 multiplier cell.
REQ-009 SHALL have port Cmult_i, input, 32, the multiplier product (combinational from Amult_o/Bmult_o).
REQ-010 SHALL have port Irq_o, output, 1, done interrupt.

Function
REQ-011 SHALL assert WBs_ACK_o one cycle after CYC&STB&~ACK is high, for exactly 1 cycle; a write takes effect on the cycle CYC&STB&WE&~ACK is high.
REQ-012 SHALL decode the following register map.
- 0x0 CTRL (W): bit0 START (self-clearing), bit1 CLR_ACC, bit2 IRQ_EN (stored; reads back bit2 only).
- 0x1 STATUS (R): bit0 busy, bit1 done, bit2 fifo_full, bit3 fifo_empty, bit4 acc_ovf, bit5 push_err, [11:8] fifo_count, others 0.
- 0x1 STATUS (W): write 1 clears bit4 and bit5.
- 0x2 OPERAND (W): push {B=DAT[31:16], A=DAT[15:0]}.
- 0x3 ACC_LO (R): acc[31:0].
- 0x4 ACC_HI (R): {24'h0, acc[39:32]}.
- 0x5 PAIR_CNT (R): {16'h0, pairs accumulated since last CLR_ACC}.
- Any other address reads 32'hFABDEFAC.
REQ-013 SHALL accept a write to CTRL or OPERAND only when WBs_BYTE_STB_i[0] is 1; the write is otherwise ignored.
REQ-014 SHALL drop a push to a full FIFO and set push_err (sticky) on it; a push to a non-full FIFO increments fifo_count.
REQ-015 SHALL provide FIFO_DEPTH entries with wrapping read and write pointers; a simultaneous push and pop leaves the count unchanged.
REQ-016 SHALL implement an FSM with states IDLE, POP, MULT, ACCUM and DONE.
- IDLE: START with a non-empty FIFO goes to POP; START with an empty FIFO goes to DONE.
- POP: dequeue one entry into registered Amult_o/Bmult_o, set Valid_mult_o=1, go to MULT.
- MULT: register Cmult_i into prod_r, go to ACCUM.
- ACCUM: acc <= acc + prod_r (40-bit unsigned) and PAIR_CNT+1; go to POP if the FIFO is non-empty, otherwise to DONE.
- DONE: set done, deassert Valid_mult_o, go to IDLE.
REQ-017 SHALL process each pair in 3 cycles; a pair pushed while busy SHALL be consumed in the same run if it arrives before the FIFO-empty check in ACCUM.
REQ-018 SHALL set acc_ovf (sticky) on a carry out of acc bit 39; acc wraps modulo 2^40.
REQ-019 SHALL make busy=1 in the POP, MULT and ACCUM states.
REQ-020 SHALL hold done until the next START or a CLR_ACC.
REQ-021 SHALL ignore START while busy.
REQ-022 SHALL ignore CLR_ACC while busy; when not busy, CLR_ACC zeroes acc, PAIR_CNT and done.
REQ-023 SHALL drive Irq_o = done & IRQ_EN, combinationally.
REQ-024 SHALL, when START and CLR_ACC are written together in IDLE, perform the clear first and then start the run.

Reset
REQ-025 SHALL, while WBs_RST_i is high, force: FSM=IDLE, FIFO empty with pointers 0, acc=0, PAIR_CNT=0, prod_r=0, all status flags 0, IRQ_EN=0, Amult_o=0, Bmult_o=0, Valid_mult_o=0, WBs_ACK_o=0, Irq_o=0.
REQ-026 SHALL, on reset asserted mid-run, abort the run and discard FIFO contents, with no partial accumulation retained.

Verification
REQ-027 SHALL verify: push (3,4),(5,6),(0xFFFF,0xFFFF); START -> DONE after 9 busy cycles, ACC_LO=0xFFFE002B, ACC_HI=0, PAIR_CNT=3, done=1.
REQ-028 SHALL verify: 9 pushes with FIFO_DEPTH=8 -> fifo_full=1 after the 8th, push_err=1, fifo_count=8; STATUS write 0x20 -> push_err=0.
REQ-029 SHALL verify: START with an empty FIFO -> done=1 within 2 cycles, acc unchanged, PAIR_CNT=0; with IRQ_EN=1 -> Irq_o=1.
REQ-030 SHALL verify: preload acc near 2^40 via 256 pushes of (0xFFFF,0xFFFF) plus repeated runs -> on wrap acc_ovf=1 and acc=sum mod 2^40.
REQ-031 SHALL verify: assert WBs_RST_i during ACCUM with 4 pairs queued -> all outputs at reset values, fifo_empty=1, ACC_LO=0 after release.
REQ-032 SHALL verify: CLR_ACC while busy -> ignored and acc final value correct; a read of unmapped address 0x7F -> 0xFABDEFAC with ACK for 1 cycle.
